// File: rtl/ni_inject.sv
`default_nettype none
// ni_inject: core-side network-interface transmitter for router local port 0.
// Builds head/body/tail flits, picks a VC round-robin and tracks per-VC credits.
module ni_inject #(
  parameter int NODE_W    = 5,
  parameter int DATA_W    = 32,
  parameter int VCH_N     = 2,
  parameter int VCH_W     = 1,
  parameter int BUF_DEPTH = 4,
  parameter int CRD_W     = 3,
  parameter int LEN_W     = 4
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [NODE_W-1:0] my_id,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [NODE_W-1:0] req_dst,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic [DATA_W-1:0] data_in,
  output logic              flit_valid,
  output logic [1:0]        flit_type,
  output logic [DATA_W-1:0] flit_data,
  output logic [VCH_W-1:0]  flit_vch,
  input  logic              credit_valid,
  input  logic [VCH_W-1:0]  credit_vch,
  output logic              crd_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, HEAD = 2'd1, BODY = 2'd2} state_t;

  localparam logic [CRD_W-1:0] CRD_FULL = CRD_W'(BUF_DEPTH);

  state_t                  state;
  logic [CRD_W-1:0]        crd [VCH_N];
  logic [VCH_W-1:0]        rr, vc, sel, idx;
  logic [NODE_W-1:0]       dst;
  logic [LEN_W-1:0]        len, rem;
  logic                    run;
  logic                    any_crd, vc_crd, found;
  logic                    send_head, send_body, send, accept;
  logic [VCH_N-1:0]        inc, dec, ovf;
  logic [DATA_W-1:0]       head_word;

  always_comb begin
    any_crd = 1'b0;
    sel     = rr;
    found   = 1'b0;
    idx     = rr;
    for (int i = 0; i < VCH_N; i++) begin
      idx = rr + VCH_W'(i);
      if (crd[i] != '0) any_crd = 1'b1;
      if (!found && crd[idx] != '0) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    head_word = '0;
    head_word[2*NODE_W-1:0] = {my_id, dst};
  end

  // run gates acceptance until the first clock edge after reset release
  assign vc_crd     = (crd[vc] != '0);
  assign req_ready  = run && (state == IDLE) && any_crd;
  assign data_ready = (state == BODY) && vc_crd;
  assign accept     = req_valid && req_ready;
  assign send_head  = (state == HEAD) && vc_crd;
  assign send_body  = data_ready && data_valid;
  assign send       = send_head || send_body;

  always_comb begin
    for (int v = 0; v < VCH_N; v++) begin
      dec[v] = send && (vc == VCH_W'(v));
      inc[v] = credit_valid && (credit_vch == VCH_W'(v));
      ovf[v] = inc[v] && !dec[v] && (crd[v] == CRD_FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int v = 0; v < VCH_N; v++) crd[v] <= CRD_FULL;
      crd_err <= 1'b0;
    end else begin
      for (int v = 0; v < VCH_N; v++) begin
        if (dec[v] && !inc[v])
          crd[v] <= crd[v] - 1'b1;
        else if (inc[v] && !dec[v] && crd[v] != CRD_FULL)
          crd[v] <= crd[v] + 1'b1;
      end
      if (|ovf) crd_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state      <= IDLE;
      rr         <= '0;
      vc         <= '0;
      dst        <= '0;
      len        <= '0;
      rem        <= '0;
      run        <= 1'b0;
      flit_valid <= 1'b0;
      flit_type  <= 2'b00;
      flit_data  <= '0;
      flit_vch   <= '0;
    end else begin
      run        <= 1'b1;
      flit_valid <= send;
      case (state)
        IDLE: begin
          if (accept) begin
            dst   <= req_dst;
            len   <= req_len;
            vc    <= sel;
            rr    <= sel + 1'b1;
            state <= HEAD;
          end
        end
        HEAD: begin
          if (send_head) begin
            flit_type <= (len == '0) ? 2'b11 : 2'b01;
            flit_data <= head_word;
            flit_vch  <= vc;
            rem       <= len;
            state     <= (len == '0) ? IDLE : BODY;
          end
        end
        BODY: begin
          if (send_body) begin
            flit_type <= (rem == LEN_W'(1)) ? 2'b10 : 2'b00;
            flit_data <= data_in;
            flit_vch  <= vc;
            rem       <= rem - 1'b1;
            if (rem == LEN_W'(1)) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ni_inject.sv
`default_nettype none
// tb_ni_inject: randomized bench for ni_inject against a packet-level reference model.
module tb_ni_inject;

  localparam int NODE_W    = 5;
  localparam int DATA_W    = 32;
  localparam int VCH_N     = 2;
  localparam int VCH_W     = 1;
  localparam int BUF_DEPTH = 4;
  localparam int CRD_W     = 3;
  localparam int LEN_W     = 4;

  logic              clk = 1'b0;
  logic              rst_ = 1'b0;
  logic [NODE_W-1:0] my_id;
  logic              req_valid, req_ready;
  logic [NODE_W-1:0] req_dst;
  logic [LEN_W-1:0]  req_len;
  logic              data_valid, data_ready;
  logic [DATA_W-1:0] data_in;
  logic              flit_valid;
  logic [1:0]        flit_type;
  logic [DATA_W-1:0] flit_data;
  logic [VCH_W-1:0]  flit_vch;
  logic              credit_valid;
  logic [VCH_W-1:0]  credit_vch;
  logic              crd_err;

  always #5 clk = ~clk;

  ni_inject #(
    .NODE_W(NODE_W), .DATA_W(DATA_W), .VCH_N(VCH_N), .VCH_W(VCH_W),
    .BUF_DEPTH(BUF_DEPTH), .CRD_W(CRD_W), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst_(rst_), .my_id(my_id),
    .req_valid(req_valid), .req_ready(req_ready), .req_dst(req_dst), .req_len(req_len),
    .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
    .flit_valid(flit_valid), .flit_type(flit_type), .flit_data(flit_data), .flit_vch(flit_vch),
    .credit_valid(credit_valid), .credit_vch(credit_vch), .crd_err(crd_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: packet-level view of credits, round robin and the flit sequence.
  int                m_crd [VCH_N];
  int                m_rr, m_rem, m_len, m_vc;
  bit                m_err, m_armed, m_busy, m_head;
  logic [NODE_W-1:0] m_dst;
  int                crd_prob;
  bit                allow_ovf;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_crd[v]) m_crd[v] = BUF_DEPTH;
    m_rr = 0; m_err = 0; m_armed = 0; m_busy = 0; m_head = 0;
    m_rem = 0; m_len = 0; m_vc = 0; m_dst = '0;
  endtask

  task automatic idle_inputs();
    req_valid = 0; req_dst = '0; req_len = '0;
    data_valid = 0; data_in = '0; credit_valid = 0; credit_vch = '0;
  endtask

  task automatic drive();
    int v;
    req_valid  = ($urandom_range(0, 99) < 50);
    req_dst    = NODE_W'($urandom);
    req_len    = LEN_W'($urandom_range(0, 6));
    data_valid = ($urandom_range(0, 99) < 75);
    data_in    = $urandom;
    v          = $urandom_range(0, VCH_N - 1);
    credit_vch = VCH_W'(v);
    credit_valid = ($urandom_range(0, 99) < crd_prob) && (allow_ovf || m_crd[v] < BUF_DEPTH);
  endtask

  // One clock: predict handshakes from stable inputs, then check the registered flit.
  task automatic cycle();
    bit                any, exp_rr, exp_dr, send, acc, cv;
    int                sel, svc, cvv, alen;
    logic [1:0]        et;
    logic [DATA_W-1:0] ed;
    logic [NODE_W-1:0] adst;
    @(negedge clk);
    any = 0;
    foreach (m_crd[v]) if (m_crd[v] > 0) any = 1;
    exp_rr = m_armed && !m_busy && any;
    exp_dr = m_busy && !m_head && (m_crd[m_vc] > 0);
    check("req_ready", req_ready, exp_rr);
    check("data_ready", data_ready, exp_dr);
    send = 0; et = 2'b00; ed = '0; svc = m_vc;
    if (m_busy && m_head && m_crd[m_vc] > 0) begin
      send = 1;
      et   = (m_len == 0) ? 2'b11 : 2'b01;
      ed   = (DATA_W'(my_id) << NODE_W) | DATA_W'(m_dst);
    end else if (exp_dr && data_valid) begin
      send = 1;
      et   = (m_rem == 1) ? 2'b10 : 2'b00;
      ed   = data_in;
    end
    acc = req_valid && exp_rr;
    sel = m_rr;
    for (int i = VCH_N - 1; i >= 0; i--)
      if (m_crd[(m_rr + i) % VCH_N] > 0) sel = (m_rr + i) % VCH_N;
    adst = req_dst; alen = int'(req_len);
    cv = credit_valid; cvv = int'(credit_vch);

    @(posedge clk); #1;
    check("flit_valid", flit_valid, send);
    if (send) begin
      check("flit_type", flit_type, et);
      check("flit_data", flit_data, ed);
      check("flit_vch", flit_vch, svc);
    end

    if (send) begin
      if (m_head) begin
        m_head = 0;
        m_rem  = m_len;
        if (m_len == 0) m_busy = 0;
      end else begin
        m_rem--;
        if (m_rem == 0) m_busy = 0;
      end
    end
    if (acc) begin
      m_busy = 1; m_head = 1; m_dst = adst; m_len = alen;
      m_vc = sel; m_rr = (sel + 1) % VCH_N;
    end
    for (int v = 0; v < VCH_N; v++) begin
      bit d, u;
      d = send && (svc == v);
      u = cv && (cvv == v);
      if (d && !u) m_crd[v]--;
      else if (u && !d) begin
        if (m_crd[v] == BUF_DEPTH) m_err = 1;
        else m_crd[v]++;
      end
    end
    check("crd_err", crd_err, m_err);
    m_armed = 1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_flit_valid"}, flit_valid, 0);
    check({tag, "_flit_type"}, flit_type, 0);
    check({tag, "_flit_data"}, flit_data, 0);
    check({tag, "_flit_vch"}, flit_vch, 0);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_data_ready"}, data_ready, 0);
    check({tag, "_crd_err"}, crd_err, 0);
  endtask

  initial begin
    int guard;
    idle_inputs();
    my_id = NODE_W'(3);
    crd_prob = 30; allow_ovf = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check_reset_outputs("rst");
    @(posedge clk); #2;
    rst_ = 1;

    // header-only packet to node 17 from node 3, then a second one on the other VC
    cycle();
    req_valid = 1; req_dst = NODE_W'(17); req_len = '0;
    cycle();
    req_valid = 0;
    cycle();
    check("hdr_only_vch0", flit_vch, 0);
    req_valid = 1; req_dst = NODE_W'(9); req_len = '0;
    cycle();
    req_valid = 0;
    cycle();
    check("rr_second_vch1", flit_vch, 1);

    // 3-payload packet with continuous data and no credit returns
    req_valid = 1; req_dst = NODE_W'(2); req_len = LEN_W'(3);
    cycle();
    req_valid = 0; data_valid = 1;
    repeat (5) begin
      data_in = $urandom;
      cycle();
    end
    data_valid = 0;

    repeat (1200) begin
      if ($urandom_range(0, 99) < 2) my_id = NODE_W'($urandom);
      drive();
      cycle();
    end

    // credit starvation: stalls and req_ready low once every VC is drained
    crd_prob = 0;
    repeat (80) begin drive(); cycle(); end
    crd_prob = 40;
    repeat (300) begin drive(); cycle(); end

    // returns at a full counter raise the sticky error
    allow_ovf = 1; crd_prob = 60;
    repeat (150) begin drive(); cycle(); end
    allow_ovf = 0; crd_prob = 30;

    // reset in the middle of a packet body
    guard = 0;
    while (!(m_busy && !m_head && m_rem >= 2) && guard < 300) begin
      drive();
      req_len = LEN_W'($urandom_range(3, 6));
      cycle();
      guard++;
    end
    check("reached_body", (m_busy && !m_head && m_rem >= 2), 1);
    #1;
    rst_ = 0;
    #2;
    check_reset_outputs("midrst");
    model_reset();
    idle_inputs();
    @(posedge clk); #2;
    rst_ = 1;
    repeat (400) begin drive(); cycle(); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
